// File: rtl/ker_osc_pkg.sv
// Shared types and default timing for the kernel-clock oscillator request controller.
//   osc_state_e : controller state encoding (3 bits)
//   DEF_*       : default parameter values for ker_osc_req_ctrl
//   max_u       : constant helper used to size the shared counter
package ker_osc_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_START = 3'd1,
    ST_ON    = 3'd2,
    ST_HOLD  = 3'd3,
    ST_STOP  = 3'd4,
    ST_ERR   = 3'd5
  } osc_state_e;

  localparam int unsigned DEF_REQ_NUM         = 8;
  localparam int unsigned DEF_STARTUP_TIMEOUT = 1023;
  localparam int unsigned DEF_OFF_DELAY       = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ker_osc_req_ctrl.sv
// Shared-oscillator (CSI/HSI) request controller for the per-peripheral kernel clock path.
// Merges the peripheral kernel-clock requests with a software force-on bit, sequences the
// oscillator (enable, wait ready, hold-off, wait not-ready) and hands out per-requester grants
// only while the oscillator is stable.
//
// Ports
//   i_clk        in   clock
//   sys_rst      in   synchronous reset, active-high
//   per_ker_req  in   [REQ_NUM] per-peripheral kernel-clock request (level)
//   osc_force_on in   software oscillator-on bit (level)
//   osc_rdy      in   oscillator ready, already synchronous to i_clk
//   err_clr      in   single-cycle pulse, clears startup_err and leaves ERR
//   osc_en       out  oscillator enable
//   osc_gnt      out  [REQ_NUM] per-requester grant, kernel clock usable
//   osc_busy     out  controller not in OFF
//   startup_err  out  sticky error: startup timeout or ready loss
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | oscillator off, idle
// START | oscillator enabled, waiting for osc_rdy (bounded by timeout)
// ON    | oscillator stable, grants follow requests
// HOLD  | no request, oscillator kept on for OFF_DELAY cycles
// STOP  | oscillator disabled, waiting for osc_rdy to fall
// ERR   | startup timeout or ready loss, waiting for err_clr
module ker_osc_req_ctrl
  import ker_osc_pkg::*;
#(
  parameter int unsigned REQ_NUM         = DEF_REQ_NUM,
  parameter int unsigned STARTUP_TIMEOUT = DEF_STARTUP_TIMEOUT,
  parameter int unsigned OFF_DELAY       = DEF_OFF_DELAY
) (
  input  logic               i_clk,
  input  logic               sys_rst,
  input  logic [REQ_NUM-1:0] per_ker_req,
  input  logic               osc_force_on,
  input  logic               osc_rdy,
  input  logic               err_clr,
  output logic               osc_en,
  output logic [REQ_NUM-1:0] osc_gnt,
  output logic               osc_busy,
  output logic               startup_err
);

  localparam int unsigned CNT_W = $clog2(max_u(STARTUP_TIMEOUT, OFF_DELAY) + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(OFF_DELAY - 1);

  osc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               osc_en_q, osc_en_d;
  logic [REQ_NUM-1:0] osc_gnt_q, osc_gnt_d;
  logic               osc_busy_q, osc_busy_d;
  logic               startup_err_q, startup_err_d;
  logic               any_req;

  always_comb begin
    any_req = (|per_ker_req) | osc_force_on;
    // Saturating increment keeps the counter from wrapping back into a compare window.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    startup_err_d = startup_err_q;
    osc_gnt_d     = '0;

    case (state_q)
      ST_OFF: begin
        if (any_req) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        // Ready wins over a timeout landing in the same cycle.
        if (osc_rdy) begin
          state_d = ST_ON;
        end else if (cnt_q == START_LAST) begin
          state_d       = ST_ERR;
          startup_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_ON: begin
        if (!osc_rdy) begin
          state_d       = ST_ERR;
          startup_err_d = 1'b1;
        end else begin
          osc_gnt_d = per_ker_req;
          if (!any_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end

      ST_HOLD: begin
        if (!osc_rdy) begin
          state_d       = ST_ERR;
          startup_err_d = 1'b1;
        end else begin
          osc_gnt_d = per_ker_req;
          if (any_req) begin
            state_d = ST_ON;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_STOP: begin
        if (!osc_rdy) begin
          state_d = ST_OFF;
        end
      end

      ST_ERR: begin
        if (err_clr) begin
          state_d       = ST_STOP;
          startup_err_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    osc_en_d   = (state_d == ST_START) || (state_d == ST_ON) || (state_d == ST_HOLD);
    osc_busy_d = (state_d != ST_OFF);
  end

  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      state_q       <= ST_OFF;
      cnt_q         <= '0;
      osc_en_q      <= 1'b0;
      osc_gnt_q     <= '0;
      osc_busy_q    <= 1'b0;
      startup_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      osc_en_q      <= osc_en_d;
      osc_gnt_q     <= osc_gnt_d;
      osc_busy_q    <= osc_busy_d;
      startup_err_q <= startup_err_d;
    end
  end

  assign osc_en      = osc_en_q;
  assign osc_gnt     = osc_gnt_q;
  assign osc_busy    = osc_busy_q;
  assign startup_err = startup_err_q;

endmodule

// File: tb/tb_ker_osc_req_ctrl.sv
// Bench for ker_osc_req_ctrl: directed scenarios followed by random stimulus, with every cycle
// compared against a phase/age reference model of the oscillator sequencing rules.
module tb_ker_osc_req_ctrl;

  localparam int N  = 8;
  localparam int TO = 1023;
  localparam int OD = 16;

  // Reference model phases.
  localparam int P_IDLE   = 0;
  localparam int P_WAKE   = 1;
  localparam int P_RUN    = 2;
  localparam int P_LINGER = 3;
  localparam int P_DRAIN  = 4;
  localparam int P_FAULT  = 5;

  logic         i_clk = 1'b0;
  logic         sys_rst;
  logic [N-1:0] per_ker_req;
  logic         osc_force_on;
  logic         osc_rdy;
  logic         err_clr;
  logic         osc_en;
  logic [N-1:0] osc_gnt;
  logic         osc_busy;
  logic         startup_err;

  int vectors     = 0;
  int miscompares = 0;

  int           m_phase = P_IDLE;
  int           m_age   = 0;
  logic         m_err   = 1'b0;
  logic [N-1:0] m_gnt   = '0;
  logic         m_en;
  logic         m_busy;

  always #5 i_clk = ~i_clk;

  ker_osc_req_ctrl #(
    .REQ_NUM        (N),
    .STARTUP_TIMEOUT(TO),
    .OFF_DELAY      (OD)
  ) dut (
    .i_clk       (i_clk),
    .sys_rst     (sys_rst),
    .per_ker_req (per_ker_req),
    .osc_force_on(osc_force_on),
    .osc_rdy     (osc_rdy),
    .err_clr     (err_clr),
    .osc_en      (osc_en),
    .osc_gnt     (osc_gnt),
    .osc_busy    (osc_busy),
    .startup_err (startup_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the sequencing rules, written in terms of phase and time spent in it.
  task automatic model_step();
    int  nxt;
    bit  any;
    bit  granting_before;
    any = (per_ker_req != '0) || osc_force_on;
    if (sys_rst) begin
      m_phase = P_IDLE;
      m_age   = 0;
      m_err   = 1'b0;
      m_gnt   = '0;
    end else begin
      nxt = m_phase;
      case (m_phase)
        P_IDLE:   if (any) nxt = P_WAKE;
        P_WAKE:   if (osc_rdy) nxt = P_RUN;
                  else if (m_age + 1 == TO) begin nxt = P_FAULT; m_err = 1'b1; end
        P_RUN:    if (!osc_rdy) begin nxt = P_FAULT; m_err = 1'b1; end
                  else if (!any) nxt = P_LINGER;
        P_LINGER: if (!osc_rdy) begin nxt = P_FAULT; m_err = 1'b1; end
                  else if (any) nxt = P_RUN;
                  else if (m_age + 1 == OD) nxt = P_DRAIN;
        P_DRAIN:  if (!osc_rdy) nxt = P_IDLE;
        P_FAULT:  if (err_clr) begin nxt = P_DRAIN; m_err = 1'b0; end
        default:  nxt = P_IDLE;
      endcase
      granting_before = (m_phase == P_RUN) || (m_phase == P_LINGER);
      m_gnt = (granting_before && (nxt == P_RUN || nxt == P_LINGER)) ? per_ker_req : '0;
      m_age = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
    end
    m_en   = (m_phase == P_WAKE) || (m_phase == P_RUN) || (m_phase == P_LINGER);
    m_busy = (m_phase != P_IDLE);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    chk("model_en",   32'(osc_en),      32'(m_en));
    chk("model_gnt",  32'(osc_gnt),     32'(m_gnt));
    chk("model_busy", 32'(osc_busy),    32'(m_busy));
    chk("model_err",  32'(startup_err), 32'(m_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   32'(osc_en),      32'd0);
    chk({tag, "_gnt"},  32'(osc_gnt),     32'd0);
    chk({tag, "_busy"}, 32'(osc_busy),    32'd0);
    chk({tag, "_err"},  32'(startup_err), 32'd0);
  endtask

  initial begin
    sys_rst      = 1'b1;
    per_ker_req  = '0;
    osc_force_on = 1'b0;
    osc_rdy      = 1'b0;
    err_clr      = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    sys_rst = 1'b0;
    tick();
    chk("idle_busy", 32'(osc_busy), 32'd0);

    // Single request, ready five cycles after enable.
    per_ker_req = 8'h04;
    tick();
    chk("start_en", 32'(osc_en), 32'd1);
    chk("start_gnt", 32'(osc_gnt), 32'd0);
    repeat (4) tick();
    osc_rdy = 1'b1;
    tick();
    chk("on_entry_gnt", 32'(osc_gnt), 32'd0);
    tick();
    chk("on_gnt", 32'(osc_gnt), 32'h04);

    // Requests drop, req[0] returns in HOLD cycle 10.
    per_ker_req = '0;
    tick();
    repeat (10) begin
      tick();
      chk("hold_en", 32'(osc_en), 32'd1);
    end
    per_ker_req = 8'h01;
    tick();
    chk("hold_ret_gnt", 32'(osc_gnt), 32'h01);
    chk("hold_ret_en", 32'(osc_en), 32'd1);

    // Requests drop with no return: exactly OD cycles of HOLD.
    per_ker_req = '0;
    tick();
    repeat (OD - 1) begin
      tick();
      chk("hold_full_en", 32'(osc_en), 32'd1);
    end
    tick();
    chk("stop_en", 32'(osc_en), 32'd0);
    chk("stop_busy", 32'(osc_busy), 32'd1);
    per_ker_req = 8'h02;
    repeat (3) begin
      tick();
      chk("stop_noabort_en", 32'(osc_en), 32'd0);
    end
    osc_rdy = 1'b0;
    tick();
    chk("off_busy", 32'(osc_busy), 32'd0);
    tick();
    chk("restart_en", 32'(osc_en), 32'd1);

    // Startup timeout: exactly TO cycles in START.
    repeat (TO - 2) begin
      tick();
      chk("timeout_wait_err", 32'(startup_err), 32'd0);
    end
    tick();
    chk("timeout_last_en", 32'(osc_en), 32'd1);
    tick();
    chk("timeout_err", 32'(startup_err), 32'd1);
    chk("timeout_en", 32'(osc_en), 32'd0);
    chk("timeout_gnt", 32'(osc_gnt), 32'd0);
    repeat (3) begin
      tick();
      chk("err_ignores_req", 32'(osc_en), 32'd0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", 32'(startup_err), 32'd0);
    chk("clr_busy", 32'(osc_busy), 32'd1);
    tick();
    chk("clr_off_busy", 32'(osc_busy), 32'd0);
    tick();
    chk("clr_restart_en", 32'(osc_en), 32'd1);

    // Ready loss in ON with all requests.
    osc_rdy     = 1'b1;
    per_ker_req = 8'hFF;
    tick();
    tick();
    chk("all_gnt", 32'(osc_gnt), 32'hFF);
    osc_rdy = 1'b0;
    tick();
    chk("loss_gnt", 32'(osc_gnt), 32'd0);
    chk("loss_en", 32'(osc_en), 32'd0);
    chk("loss_err", 32'(startup_err), 32'd1);
    per_ker_req = '0;
    err_clr     = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("loss_off_busy", 32'(osc_busy), 32'd0);

    // Reset in START, then force-on restart without grants.
    per_ker_req = 8'h01;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    chk_all_zero("rst_start");
    sys_rst      = 1'b0;
    per_ker_req  = '0;
    osc_force_on = 1'b1;
    tick();
    chk("force_en", 32'(osc_en), 32'd1);
    osc_rdy = 1'b1;
    tick();
    tick();
    chk("force_gnt", 32'(osc_gnt), 32'd0);
    chk("force_on_en", 32'(osc_en), 32'd1);

    // Reset in HOLD.
    osc_force_on = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    chk_all_zero("rst_hold");
    sys_rst = 1'b0;
    tick();
    chk("rst_hold_idle", 32'(osc_busy), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) per_ker_req = N'($urandom);
      else if ($urandom_range(0, 15) == 0) per_ker_req = '0;
      if ($urandom_range(0, 63) == 0) osc_force_on = ~osc_force_on;
      if (m_en && !osc_rdy && $urandom_range(0, 3) == 0) osc_rdy = 1'b1;
      else if (m_en && osc_rdy && $urandom_range(0, 199) == 0) osc_rdy = 1'b0;
      else if (!m_en && osc_rdy && $urandom_range(0, 2) == 0) osc_rdy = 1'b0;
      err_clr = ($urandom_range(0, 9) == 0);
      sys_rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
